// File: rtl/add_sequencer.sv
// add_sequencer: operator button sequencer for the shared W-bit adder.
// Loads A then B from switches, issues a one-cycle start, waits for done
// (with a timeout watchdog), and holds the W+1-bit result for display.
// Accumulate mode chains the previous result (carry dropped) in as A.
module add_sequencer #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enter_push,
  input  logic         clear_push,
  input  logic         acc_mode,
  input  logic [W-1:0] sw,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_start,
  input  logic [W:0]   add_sum,
  input  logic         add_done,
  output logic [W:0]   result,
  output logic         result_valid,
  output logic         busy,
  output logic         error,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_SHOW  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   add_a_q, add_a_d;
  logic [W-1:0]   add_b_q, add_b_d;
  logic [W:0]     result_q, result_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;

  // State and datapath registers; reset returns everything to zero/IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      add_a_q    <= '0;
      add_b_q    <= '0;
      result_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      result_q   <= result_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and register updates; clear overrides everything else.
  always_comb begin
    state_d    = state_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    result_d   = result_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (enter_push) begin
          add_a_d = sw;
          state_d = S_GOT_A;
        end
      end
      S_GOT_A: begin
        if (enter_push) begin
          add_b_d = sw;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (add_done) begin
          result_d = add_sum;
          state_d  = S_SHOW;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_SHOW: begin
        if (enter_push) begin
          if (acc_mode) begin
            add_a_d = result_q[W-1:0];
            add_b_d = sw;
            state_d = S_ISSUE;
          end else begin
            add_a_d = sw;
            state_d = S_GOT_A;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear must also discard any operand load requested by a same-cycle enter.
    if (clear_push) begin
      state_d  = S_IDLE;
      result_d = '0;
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
    end
  end

  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign result       = result_q;
  assign state        = state_q;
  assign add_start    = (state_q == S_ISSUE);
  assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign result_valid = (state_q == S_SHOW);
  assign error        = (state_q == S_ERR);

endmodule
